// File: rtl/fuzz_sig_pkg.sv
// Shared types and default constants for the y-bus signature compactor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: run-state enum plus the default MISR width, polynomial and seed.
package fuzz_sig_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sig_state_t;

   localparam int          DEF_SIG_WIDTH = 32;
   localparam logic [31:0] DEF_POLY      = 32'h04C11DB7;
   localparam logic [31:0] DEF_SEED      = 32'h00000000;

endpackage

// File: rtl/y_fold_xor.sv
// Folds a wide bus into one SIG_WIDTH word by XOR of zero-padded word slices.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output tracks the input continuously.
//
// Ports:
//   y     in   Y_WIDTH    bus to fold
//   fold  out  SIG_WIDTH  XOR of all SIG_WIDTH-wide words of y (top word zero-padded)
module y_fold_xor #(
   parameter int Y_WIDTH   = 336,
   parameter int SIG_WIDTH = 32
) (
   input  logic [Y_WIDTH-1:0]   y,
   output logic [SIG_WIDTH-1:0] fold
);

   localparam int NW = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;

   logic [NW*SIG_WIDTH-1:0] y_pad;

   always_comb begin
      y_pad              = '0;
      y_pad[Y_WIDTH-1:0] = y;
      fold               = '0;
      for (int k = 0; k < NW; k++) begin
         fold = fold ^ y_pad[k*SIG_WIDTH +: SIG_WIDTH];
      end
   end

endmodule

// File: rtl/y_signature_compactor.sv
// Compacts a run of y samples into a MISR signature and compares it against golden.
// Latency: an accepted sample is reflected on signature/sample_cnt one edge later; done rises on the edge accepting the last sample.
// Backpressure: none; every cycle with y_valid high in RUN is consumed.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start, abort        run control pulses (abort wins over start)
//   y_in, y_valid       observed bus and its sample strobe
//   golden              expected signature, sampled as the run completes
//   busy, done, match   run status (match meaningful only while done)
//   signature           current MISR value
//   sample_cnt          samples accepted in the current run
module y_signature_compactor
   import fuzz_sig_pkg::*;
#(
   parameter int                   Y_WIDTH      = 336,
   parameter int                   SIG_WIDTH    = DEF_SIG_WIDTH,
   parameter logic [SIG_WIDTH-1:0] POLY         = DEF_POLY,
   parameter logic [SIG_WIDTH-1:0] SEED         = DEF_SEED,
   parameter int                   SAMPLE_COUNT = 20,
   parameter int                   CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [Y_WIDTH-1:0]   y_in,
   input  logic                 y_valid,
   input  logic [SIG_WIDTH-1:0] golden,
   output logic                 busy,
   output logic                 done,
   output logic                 match,
   output logic [SIG_WIDTH-1:0] signature,
   output logic [CNT_WIDTH-1:0] sample_cnt
);

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(SAMPLE_COUNT);

   sig_state_t             state_q, state_d;
   logic [SIG_WIDTH-1:0]   sig_q, sig_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   match_q, match_d;

   logic [SIG_WIDTH-1:0]   fold;
   logic [SIG_WIDTH-1:0]   sig_step;
   logic [CNT_WIDTH-1:0]   cnt_inc;
   logic                   accept;

   y_fold_xor #(
      .Y_WIDTH   (Y_WIDTH),
      .SIG_WIDTH (SIG_WIDTH)
   ) u_fold (
      .y    (y_in),
      .fold (fold)
   );

   // A start or abort in the same cycle takes priority, so that cycle's sample is dropped.
   assign accept   = (state_q == RUN) && y_valid && !start && !abort;
   assign sig_step = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold;
   assign cnt_inc  = cnt_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      match_d = match_q;
      if (abort) begin
         // Signature and count are left in place so they can be inspected after an abort.
         state_d = IDLE;
         match_d = 1'b0;
      end else if (start) begin
         state_d = RUN;
         sig_d   = SEED;
         cnt_d   = '0;
         match_d = 1'b0;
      end else if (accept) begin
         sig_d = sig_step;
         cnt_d = cnt_inc;
         if (cnt_inc == LAST_CNT) begin
            state_d = DONE;
            match_d = (sig_step == golden);
         end
      end
   end

   assign busy       = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign match      = match_q;
   assign signature  = sig_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_y_signature_compactor.sv
// Directed bench for y_signature_compactor: three instances (run lengths 20, 1 and 2) share one stimulus stream.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 time unit after the next rising edge.
// Backpressure: n/a.
module tb_y_signature_compactor;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [335:0]  y_in;
   logic          y_valid;
   logic [31:0]   golden;

   logic          busy_a, done_a, match_a;
   logic [31:0]   sig_a;
   logic [15:0]   cnt_a;
   logic          busy_b, done_b, match_b;
   logic [31:0]   sig_b;
   logic [15:0]   cnt_b;
   logic          busy_c, done_c, match_c;
   logic [31:0]   sig_c;
   logic [15:0]   cnt_c;

   int checks = 0;
   int errors = 0;

   y_signature_compactor u_dut20 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in), .y_valid(y_valid),
      .golden(golden), .busy(busy_a), .done(done_a), .match(match_a),
      .signature(sig_a), .sample_cnt(cnt_a)
   );

   y_signature_compactor #(.SAMPLE_COUNT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in), .y_valid(y_valid),
      .golden(golden), .busy(busy_b), .done(done_b), .match(match_b),
      .signature(sig_b), .sample_cnt(cnt_b)
   );

   y_signature_compactor #(.SAMPLE_COUNT(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in), .y_valid(y_valid),
      .golden(golden), .busy(busy_c), .done(done_c), .match(match_c),
      .signature(sig_c), .sample_cnt(cnt_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Independent reference: zero-pad to 11 words, XOR them, then one MISR shift.
   function automatic logic [31:0] ref_fold(input logic [335:0] y);
      logic [351:0] p;
      logic [31:0]  f;
      p = '0;
      p[335:0] = y;
      f = '0;
      for (int k = 0; k < 11; k++) f = f ^ p[k*32 +: 32];
      return f;
   endfunction

   function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [31:0] f);
      return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
   endfunction

   initial begin
      logic [31:0] exp_sig;
      logic [31:0] prev_sig;
      logic        v;

      rst = 1'b1; start = 1'b0; abort = 1'b0; y_in = '0; y_valid = 1'b0; golden = '0;
      #12;
      chk("reset_busy", busy_a, 0);
      chk("reset_done", done_a, 0);
      chk("reset_match", match_a, 0);
      chk("reset_sig", sig_a, 32'h0);
      chk("reset_cnt", cnt_a, 0);
      rst = 1'b0;

      // Single-sample run, all-zero sample.
      tick();
      golden = 32'h0;
      pulse_start();
      chk("n1_busy_after_start", busy_b, 1);
      y_in = '0; y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      chk("n1_done", done_b, 1);
      chk("n1_sig", sig_b, 32'h0);
      chk("n1_match", match_b, 1);
      chk("n1_busy_low", busy_b, 0);

      // Fold coverage on single-sample runs.
      golden = 32'h1;
      pulse_start();
      y_in = '0; y_in[32] = 1'b1; y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      chk("fold_bit32", sig_b, 32'h1);
      chk("fold_bit32_match", match_b, 1);

      pulse_start();
      y_in = '0; y_in[335] = 1'b1; y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      chk("fold_bit335", sig_b, 32'h8000);
      chk("fold_bit335_nomatch", match_b, 0);

      pulse_start();
      y_in = '0; y_in[0] = 1'b1; y_in[32] = 1'b1; y_valid = 1'b1;
      tick();
      y_valid = 1'b0;
      chk("fold_bits0_32", sig_b, 32'h0);

      // Two-sample runs: bit0 twice gives 1 then 3.
      golden = 32'h3;
      pulse_start();
      y_in = '0; y_in[0] = 1'b1; y_valid = 1'b1;
      tick();
      chk("n2_sig1", sig_c, 32'h1);
      chk("n2_cnt1", cnt_c, 1);
      chk("n2_not_done", done_c, 0);
      tick();
      chk("n2_sig2", sig_c, 32'h3);
      chk("n2_done", done_c, 1);
      chk("n2_match", match_c, 1);
      tick();
      y_valid = 1'b0;
      chk("n2_frozen_sig", sig_c, 32'h3);
      chk("n2_frozen_cnt", cnt_c, 2);

      golden = 32'h2;
      pulse_start();
      y_valid = 1'b1;
      tick();
      tick();
      y_valid = 1'b0;
      chk("n2_g2_done", done_c, 1);
      chk("n2_g2_match", match_c, 0);

      // Polynomial feedback: top bit set, then a zero sample shifts it into POLY.
      golden = 32'h04C11DB7;
      pulse_start();
      y_in = '0; y_in[31] = 1'b1; y_valid = 1'b1;
      tick();
      chk("poly_sig1", sig_c, 32'h80000000);
      y_in = '0;
      tick();
      y_valid = 1'b0;
      chk("poly_sig2", sig_c, 32'h04C11DB7);
      chk("poly_match", match_c, 1);

      // Full 20-sample run with two idle cycles (3 and 7) among 22 active cycles.
      pulse_start();
      exp_sig = 32'h0;
      for (int c = 1; c <= 22; c++) begin
         v = !(c == 3 || c == 7);
         y_in = '0;
         y_in[(c * 13) % 336] = 1'b1;
         y_in[(c * 7 + 100) % 336] = 1'b1;
         y_in[31] = c[0];
         y_valid = v;
         if (v) exp_sig = ref_misr(exp_sig, ref_fold(y_in));
         golden = exp_sig;
         prev_sig = sig_a;
         tick();
         if (!v) chk($sformatf("idle_hold_c%0d", c), sig_a, prev_sig);
         if (c == 21) begin
            chk("run20_cnt19", cnt_a, 19);
            chk("run20_not_done", done_a, 0);
            chk("run20_busy", busy_a, 1);
         end
      end
      y_valid = 1'b0;
      chk("run20_cnt20", cnt_a, 20);
      chk("run20_done", done_a, 1);
      chk("run20_sig", sig_a, exp_sig);
      chk("run20_match", match_a, 1);

      // Abort in DONE keeps the signature for inspection.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_done", done_a, 0);
      chk("abort_match", match_a, 0);
      chk("abort_busy", busy_a, 0);
      chk("abort_sig_kept", sig_a, exp_sig);
      chk("abort_cnt_kept", cnt_a, 20);

      // Start with a valid sample mid-run restarts and drops that sample.
      pulse_start();
      y_in = '0; y_in[0] = 1'b1; y_valid = 1'b1;
      repeat (4) tick();
      chk("restart_pre_cnt", cnt_a, 4);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_cnt", cnt_a, 0);
      chk("restart_sig", sig_a, 32'h0);
      chk("restart_busy", busy_a, 1);

      // Asynchronous reset after five samples: bit0 each time gives 1,3,7,F,1F.
      repeat (5) tick();
      y_valid = 1'b0;
      chk("pre_rst_cnt", cnt_a, 5);
      chk("pre_rst_sig", sig_a, 32'h1F);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy_a, 0);
      chk("arst_done", done_a, 0);
      chk("arst_cnt", cnt_a, 0);
      chk("arst_sig", sig_a, 32'h0);
      #2 rst = 1'b0;
      tick();
      chk("post_rst_idle", busy_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/y_signature_compactor.md
Name: y_signature_compactor

Overview:
- Downstream consumer of the fuzz design-under-test output bus `y` (336 bits), sampled once per clock edge.
- Compacts a run of y samples into a 32-bit MISR signature, counts accepted samples, and compares the final signature against a golden value.
- Lets the synthesized netlist and the RTL model be checked against each other with one word instead of per-cycle `$strobe` text dumps.
- Fully synthesizable; single clock domain.

Parameters:
- Y_WIDTH, 336, width of the observed y bus.
- SIG_WIDTH, 32, signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial (the x^SIG_WIDTH term is implicit).
- SEED, 32'h00000000, signature value loaded on start.
- SAMPLE_COUNT, 20, number of accepted samples per run; legal range 1 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 16, sample counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins or restarts a run.
- abort  input  1  returns to IDLE without asserting done.
- y_in  input  Y_WIDTH  DUT output bus.
- y_valid  input  1  y_in is a sample to accept this cycle.
- golden  input  SIG_WIDTH  expected final signature; sampled on the RUN->DONE transition.
- busy  output  1  high in RUN.
- done  output  1  high in DONE; held until start, abort or rst.
- match  output  1  valid while done: signature == golden.
- signature  output  SIG_WIDTH  current MISR value.
- sample_cnt  output  CNT_WIDTH  samples accepted in the current run.

Behaviour:
Reset values:
- On rst: state=IDLE, busy=0, done=0, match=0, signature=SEED, sample_cnt=0.
- rst asserted mid-run discards the run; no done pulse is produced.

Fold (combinational):
- Zero-extend y_in to NW*SIG_WIDTH, where NW = ceil(Y_WIDTH/SIG_WIDTH) (11 for the defaults).
- fold = XOR of all NW words; word k is bits [k*32+31 : k*32].

MISR step, applied on each accepted sample:
- sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.

States:
- IDLE
  - start -> RUN; signature=SEED, sample_cnt=0.
  - y_valid is ignored.
- RUN
  - Accepted sample: y_valid=1 and no start/abort in the same cycle. Update signature and increment sample_cnt.
  - If the accepted sample takes sample_cnt to SAMPLE_COUNT: go to DONE, and on the same edge register match = (sig_next == golden).
  - y_valid=0: hold all state.
- DONE
  - signature, sample_cnt and match are frozen; y_valid is ignored.
  - start -> RUN (reseeded).

Priority (highest first): rst, abort, start, y_valid.
- abort in any state -> IDLE. done and match clear; signature and sample_cnt hold for debug.
- start during RUN restarts the run. That cycle's sample is not accepted.

Latency and outputs:
- Sample accepted at edge n is visible on signature/sample_cnt after edge n.
- done rises on the edge that accepts sample SAMPLE_COUNT.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- busy = (state==RUN). done = (state==DONE).

Counter:
- sample_cnt never wraps within a run, because the run ends exactly at SAMPLE_COUNT.

Decomposition:
- Shared package `fuzz_sig_pkg`: state enum (IDLE, RUN, DONE), default POLY, SEED and SIG_WIDTH constants.
- One natural sub-module, `y_fold_xor`: purely combinational, parameterized Y_WIDTH/SIG_WIDTH, with zero-pad and XOR reduction. It is reused by the stimulus-side checker.
- The FSM, MISR and counter live in the top.

Test Plan:
1. rst pulse mid-RUN after 5 samples -> busy=0, done=0, sample_cnt=0, signature=32'h0 immediately, with no clock edge needed.
2. SAMPLE_COUNT=1, start, y_in=0, y_valid=1 -> after 1 edge: done=1, signature=32'h0, match=1 with golden=0.
3. SAMPLE_COUNT=2, y_in=bit0 set twice -> signature 32'h1, then 32'h3; done after the second edge; golden=3 gives match=1, golden=2 gives match=0.
4. Fold coverage: single samples with bit 32, bit 335, and bits 0+32 set -> signature 32'h1, 32'h8000, 32'h0 respectively.
5. Default SAMPLE_COUNT=20 with y_valid low on cycles 3 and 7 -> sample_cnt reaches 20 only after 22 active cycles; samples presented while y_valid=0 do not change signature.
6. start asserted together with y_valid in RUN after 4 samples -> sample_cnt=0 and signature=SEED next cycle. abort in DONE -> done=0, match=0, and signature is retained.
